// File: rtl/rgb2ycbcr_stream.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2ycbcr_stream
//  Description : Pipelined RGB888 to YCbCr444 converter for a camera-style
//                video stream (vsync / href / clken / 24-bit pixel).
//                - Fixed 3-cycle datapath, one pixel per clock.
//                - vsync/href/clken delayed 3 cycles to stay aligned.
//                - Y/Cb/Cr forced to zero whenever post_frame_href is low.
//                - Output-side geometry checker: frame_done pulse,
//                  frame_lines count and frame_err flag per checked frame.
//  Ports       :
//    clk, rst                 pixel clock, synchronous active-high reset
//    per_frame_vsync/href/clken, per_img_rgb   input stream
//    post_frame_vsync/href/clken               delayed sync (3 cycles)
//    post_img_y/cb/cr                          converted pixel
//    frame_done, frame_err, frame_lines        geometry report
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb2ycbcr_stream #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int BGR_ORDER = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [23:0] per_img_rgb,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [7:0]  post_img_y,
    output logic [7:0]  post_img_cb,
    output logic [7:0]  post_img_cr,
    output logic        frame_done,
    output logic        frame_err,
    output logic [10:0] frame_lines
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [15:0] c_y_r   = 16'd77;
    localparam logic [15:0] c_y_g   = 16'd150;
    localparam logic [15:0] c_y_b   = 16'd29;
    localparam logic [15:0] c_cb_r  = 16'd43;
    localparam logic [15:0] c_cb_g  = 16'd85;
    localparam logic [15:0] c_cb_b  = 16'd128;
    localparam logic [15:0] c_cr_r  = 16'd128;
    localparam logic [15:0] c_cr_g  = 16'd107;
    localparam logic [15:0] c_cr_b  = 16'd21;
    localparam logic [17:0] c_bias  = 18'd32768;

    localparam logic [10:0] c_cnt_max = 11'd2047;
    localparam logic [10:0] c_hdisp   = 11'(IMG_HDISP);
    localparam logic [10:0] c_vdisp   = 11'(IMG_VDISP);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_armed  = 2'd1;
    localparam logic [1:0] c_st_active = 2'd2;

    // ------------------------------------------------------------------
    // Byte-order selection
    // ------------------------------------------------------------------
    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;

    generate
        if (BGR_ORDER != 0) begin : g_bgr
            assign w_b = per_img_rgb[23:16];
            assign w_g = per_img_rgb[15:8];
            assign w_r = per_img_rgb[7:0];
        end else begin : g_rgb
            assign w_r = per_img_rgb[23:16];
            assign w_g = per_img_rgb[15:8];
            assign w_b = per_img_rgb[7:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // S1: nine products (each fits 16 bits: max 150*255 = 38250)
    // ------------------------------------------------------------------
    logic [15:0] r_p_yr, r_p_yg, r_p_yb;
    logic [15:0] r_p_cbr, r_p_cbg, r_p_cbb;
    logic [15:0] r_p_crr, r_p_crg, r_p_crb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_yr  <= '0; r_p_yg  <= '0; r_p_yb  <= '0;
            r_p_cbr <= '0; r_p_cbg <= '0; r_p_cbb <= '0;
            r_p_crr <= '0; r_p_crg <= '0; r_p_crb <= '0;
        end else begin
            r_p_yr  <= {8'd0, w_r} * c_y_r;
            r_p_yg  <= {8'd0, w_g} * c_y_g;
            r_p_yb  <= {8'd0, w_b} * c_y_b;
            r_p_cbr <= {8'd0, w_r} * c_cb_r;
            r_p_cbg <= {8'd0, w_g} * c_cb_g;
            r_p_cbb <= {8'd0, w_b} * c_cb_b;
            r_p_crr <= {8'd0, w_r} * c_cr_r;
            r_p_crg <= {8'd0, w_g} * c_cr_g;
            r_p_crb <= {8'd0, w_b} * c_cr_b;
        end
    end

    // ------------------------------------------------------------------
    // S2: biased sums. The positive terms are added to the bias before the
    // subtractions, and the largest subtrahend (128*255) never exceeds the
    // bias, so the 18-bit sums stay non-negative.
    // ------------------------------------------------------------------
    logic [17:0] w_y_sum, w_cb_sum, w_cr_sum;
    logic [17:0] r_y_sum, r_cb_sum, r_cr_sum;

    always_comb begin
        w_y_sum  = {2'd0, r_p_yr} + {2'd0, r_p_yg} + {2'd0, r_p_yb};
        w_cb_sum = c_bias + {2'd0, r_p_cbb} - {2'd0, r_p_cbr} - {2'd0, r_p_cbg};
        w_cr_sum = c_bias + {2'd0, r_p_crr} - {2'd0, r_p_crg} - {2'd0, r_p_crb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_sum  <= '0;
            r_cb_sum <= '0;
            r_cr_sum <= '0;
        end else begin
            r_y_sum  <= w_y_sum;
            r_cb_sum <= w_cb_sum;
            r_cr_sum <= w_cr_sum;
        end
    end

    // ------------------------------------------------------------------
    // S3: take bits [15:8] (the >>8); results are always within 0..255
    // ------------------------------------------------------------------
    logic [7:0] r_y, r_cb, r_cr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y  <= '0;
            r_cb <= '0;
            r_cr <= '0;
        end else begin
            r_y  <= r_y_sum[15:8];
            r_cb <= r_cb_sum[15:8];
            r_cr <= r_cr_sum[15:8];
        end
    end

    // Discarded sum bits, collected so they read as intentionally unused.
    logic w_unused_bits;
    assign w_unused_bits = ^{r_y_sum[17:16], r_y_sum[7:0],
                             r_cb_sum[17:16], r_cb_sum[7:0],
                             r_cr_sum[17:16], r_cr_sum[7:0]};

    // ------------------------------------------------------------------
    // Sync delay line (3 deep, aligned with S3). r_vld_sr marks stages that
    // hold real input history rather than reset zeros, so the checker can
    // tell a genuine vsync-low from the artificial one after reset.
    // ------------------------------------------------------------------
    logic [2:0] r_vsync_sr, r_href_sr, r_clken_sr, r_vld_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_sr <= '0;
            r_href_sr  <= '0;
            r_clken_sr <= '0;
            r_vld_sr   <= '0;
        end else begin
            r_vsync_sr <= {r_vsync_sr[1:0], per_frame_vsync};
            r_href_sr  <= {r_href_sr[1:0],  per_frame_href};
            r_clken_sr <= {r_clken_sr[1:0], per_frame_clken};
            r_vld_sr   <= {r_vld_sr[1:0],   1'b1};
        end
    end

    assign post_frame_vsync = r_vsync_sr[2];
    assign post_frame_href  = r_href_sr[2];
    assign post_frame_clken = r_clken_sr[2];

    assign post_img_y  = r_href_sr[2] ? r_y  : 8'd0;
    assign post_img_cb = r_href_sr[2] ? r_cb : 8'd0;
    assign post_img_cr = r_href_sr[2] ? r_cr : 8'd0;

    // ------------------------------------------------------------------
    // Geometry checker
    // ------------------------------------------------------------------
    logic [1:0]  r_state, w_state_nxt;
    logic        r_vs_prev, r_hr_prev;
    logic [10:0] r_pix_cnt, w_pix_cnt_nxt;
    logic [10:0] r_line_cnt, w_line_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic        r_frame_done, w_frame_done_nxt;
    logic        r_frame_err, w_frame_err_nxt;
    logic [10:0] r_frame_lines, w_frame_lines_nxt;

    logic w_pix_inc, w_vs_rise, w_vs_fall, w_hr_fall;

    assign w_pix_inc = post_frame_href & post_frame_clken;
    assign w_vs_rise = post_frame_vsync & ~r_vs_prev;
    assign w_vs_fall = ~post_frame_vsync & r_vs_prev;
    assign w_hr_fall = ~post_frame_href & r_hr_prev;

    always_comb begin
        w_state_nxt       = r_state;
        w_pix_cnt_nxt     = r_pix_cnt;
        w_line_cnt_nxt    = r_line_cnt;
        w_err_nxt         = r_err;
        w_frame_done_nxt  = 1'b0;
        w_frame_err_nxt   = r_frame_err;
        w_frame_lines_nxt = r_frame_lines;

        case (r_state)
            c_st_idle: begin
                if (!post_frame_vsync && r_vld_sr[2]) begin
                    w_state_nxt = c_st_armed;
                end
            end

            c_st_armed: begin
                if (w_vs_rise) begin
                    w_state_nxt    = c_st_active;
                    w_pix_cnt_nxt  = w_pix_inc ? 11'd1 : 11'd0;
                    w_line_cnt_nxt = 11'd0;
                    w_err_nxt      = 1'b0;
                end
            end

            c_st_active: begin
                if (w_pix_inc && (r_pix_cnt != c_cnt_max)) begin
                    w_pix_cnt_nxt = r_pix_cnt + 11'd1;
                end
                // Line close is evaluated before frame close so that a
                // coincident href/vsync fall still counts the final line.
                if (w_hr_fall) begin
                    if (r_line_cnt != c_cnt_max) begin
                        w_line_cnt_nxt = r_line_cnt + 11'd1;
                    end
                    if (r_pix_cnt != c_hdisp) begin
                        w_err_nxt = 1'b1;
                    end
                    w_pix_cnt_nxt = 11'd0;
                end
                if (w_vs_fall) begin
                    w_frame_done_nxt  = 1'b1;
                    w_frame_lines_nxt = w_line_cnt_nxt;
                    w_frame_err_nxt   = w_err_nxt | (w_line_cnt_nxt != c_vdisp);
                    w_state_nxt       = c_st_armed;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_vs_prev     <= 1'b0;
            r_hr_prev     <= 1'b0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_err         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_lines <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_vs_prev     <= post_frame_vsync;
            r_hr_prev     <= post_frame_href;
            r_pix_cnt     <= w_pix_cnt_nxt;
            r_line_cnt    <= w_line_cnt_nxt;
            r_err         <= w_err_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_frame_lines <= w_frame_lines_nxt;
        end
    end

    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign frame_lines = r_frame_lines;

endmodule
`default_nettype wire

// File: doc/rgb2ycbcr_stream.md
# rgb2ycbcr_stream

Pipelined RGB888 → YCbCr444 converter on the camera-style video stream (vsync/href/clken/24-bit pixel), placed directly after the CMOS/BMP stream source and ahead of every luma/chroma processing stage. Converts each pixel in a fixed 3-cycle pipeline and delays the sync signals to match. Also checks frame geometry on the output side, reporting a per-frame done pulse, a line count and a geometry error flag.

## Interface
- IMG_HDISP, 640, expected active pixels per line
- IMG_VDISP, 480, expected active lines per frame
- BGR_ORDER, 1, 1: per_img_rgb = {B,G,R} (BMP byte order); 0: {R,G,B}

- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- per_frame_vsync  in  1  high = frame active, low = vertical sync/blanking
- per_frame_href  in  1  line-active qualifier
- per_frame_clken  in  1  pixel-valid strobe
- per_img_rgb  in  24  pixel; byte order per BGR_ORDER
- post_frame_vsync  out  1  per_frame_vsync delayed 3 cycles
- post_frame_href  out  1  per_frame_href delayed 3 cycles
- post_frame_clken  out  1  per_frame_clken delayed 3 cycles
- post_img_y / post_img_cb / post_img_cr  out  8 each  converted pixel
- frame_done  out  1  one-cycle pulse at end of each checked frame
- frame_err  out  1  geometry error of last checked frame; valid with frame_done, held until next frame_done
- frame_lines  out  11  lines counted in last checked frame, held until next frame_done

## Operation
- Arithmetic, unsigned 8-bit R,G,B:
  - Y  = (77R + 150G + 29B) >> 8
  - Cb = (32768 + 128B − 43R − 85G) >> 8
  - Cr = (32768 + 128R − 107G − 21B) >> 8
- Results are provably in 0..255; no clamping. Internal sums ≥ 18 bits; subtraction performed after the +32768 bias so no intermediate goes negative.
- Pipeline (free-running, advances every cycle regardless of clken):
  - S1: register 9 products
  - S2: register three biased sums
  - S3: register bits [15:8] of each sum
- Sync delay: vsync/href/clken pass through a 3-deep shift register, aligned with S3.
- Data gating: Y/Cb/Cr outputs are forced to 0 on any cycle where post_frame_href is low.
- Geometry checker, on post_* signals. States:
  - IDLE (after reset) → ARMED when post_frame_vsync is low.
  - ARMED → ACTIVE on post_frame_vsync rising edge; clears pix/line counters and the error accumulator.
  - ACTIVE:
    - Count pixels with post_frame_href & post_frame_clken.
    - On each post_frame_href falling edge: line_cnt+1; if pix_cnt ≠ IMG_HDISP, set err; clear pix_cnt.
    - On post_frame_vsync falling edge: pulse frame_done; frame_lines ← line_cnt; frame_err ← err | (line_cnt ≠ IMG_VDISP); → ARMED.
- Counters saturate at 2047; no wrap.
- Simultaneous href fall and vsync fall: the line is counted and checked first; the final line is included in frame_lines/frame_err.
- A frame already in progress at reset release is never reported. IDLE waits for vsync low, so the first frame_done follows the first complete vsync-high interval.

## Timing
- Latency: input pixel at cycle N appears on post_img_* at cycle N+3; full throughput, 1 pixel/cycle.
- Reset values:
  - All post_* outputs 0
  - frame_done 0, frame_err 0, frame_lines 0
  - Pipeline and delay registers 0
  - Checker in IDLE
- Reset mid-frame: all of the above on the next edge. No frame_done for the interrupted frame.
- frame_done asserts the cycle after post_frame_vsync is sampled low following high, i.e. input vsync fall + 4 cycles. frame_lines/frame_err update in the same cycle.

## Test plan
- Constant white (255,255,255), then black: Y=255/0, Cb=128, Cr=128 on both; output at cycle N+3.
- Single pixels R(255,0,0), G(0,255,0), B(0,0,255), BGR_ORDER=1 and 0 → Y/Cb/Cr = 76/85/255, 149/43/21, 28/255/107.
- Full 640×480 frame from the camera-timing source → post_* equal input sync delayed exactly 3 cycles; one frame_done; frame_lines=480; frame_err=0.
- Frame with one line of 639 pixels, then a frame of 479 lines → frame_err=1 for each; the following good frame reports 0.
- rst pulsed for 1 cycle mid-frame → all outputs 0 next cycle; no frame_done for that frame; next full frame reports 480/0.
- clken toggled every other cycle within href (320 valid pixels/line, IMG_HDISP=320) → data correct on strobed cycles; frame_err=0.
